sc_sng_bank: RTL

//  Stochastic number generator bank; stage directly upstream of the SC MUX neuron.

---
 rtl/sc_pkg.sv | 37 +++
 rtl/sc_lfsr.sv | 48 ++++
 rtl/sc_sng_bank.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/sc_pkg.sv
// -----------------------------------------------------------------------------
// sc_pkg
// Shared types and helpers for the stochastic number generator bank.
//   sng_state_t : FSM state encoding (IDLE, RUN, DONE).
//   lfsr_taps   : Galois toggle mask of a maximal-length LFSR for widths 4..16.
//                 Bit b of the mask is the x^(b+1) term of the feedback
//                 polynomial. The register shifts right and XORs the mask in
//                 when the bit shifted out is 1.
// -----------------------------------------------------------------------------
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sng_state_t;

    function automatic logic [15:0] lfsr_taps(input int w);
        case (w)
            4:       return 16'h000C;  // x^4+x^3+1
            5:       return 16'h0014;  // x^5+x^3+1
            6:       return 16'h0030;  // x^6+x^5+1
            7:       return 16'h0060;  // x^7+x^6+1
            8:       return 16'h00B8;  // x^8+x^6+x^5+x^4+1
            9:       return 16'h0110;  // x^9+x^5+1
            10:      return 16'h0240;  // x^10+x^7+1
            11:      return 16'h0500;  // x^11+x^9+1
            12:      return 16'h0E08;  // x^12+x^11+x^10+x^4+1
            13:      return 16'h1C80;  // x^13+x^12+x^11+x^8+1
            14:      return 16'h3802;  // x^14+x^13+x^12+x^2+1
            15:      return 16'h6000;  // x^15+x^14+1
            16:      return 16'hB400;  // x^16+x^14+x^13+x^11+1
            default: return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/sc_lfsr.sv
// -----------------------------------------------------------------------------
// sc_lfsr
// W-bit maximal-length Galois LFSR. It walks the states 1..2**W-1 and never
// reaches zero. Reseed has priority over stepping.
// Ports:
//   clk    in  1  rising-edge clock
//   reset  in  1  asynchronous active-low reset; loads SEED
//   en     in  1  advance one step this cycle
//   reseed in  1  load SEED this cycle
//   state  out W  current LFSR value
// -----------------------------------------------------------------------------
module sc_lfsr
    import sc_pkg::*;
#(
    parameter int             W    = 8,
    parameter logic [W-1:0]   SEED = W'(8'h01)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         reseed,
    output logic [W-1:0] state
);

    localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

    logic [W-1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (reseed) begin
            state_d = SEED;
        end else if (en) begin
            state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/sc_sng_bank.sv
// -----------------------------------------------------------------------------
// sc_sng_bank
// Stochastic number generator bank that feeds the SC MUX neuron. One handshake
// captures N = 2**K activations and N weights. The bank then emits STREAM_LEN
// cycles of unipolar bitstreams (bit = LFSR <= operand) plus a mux select per
// cycle. done pulses for one cycle after the last stream bit.
//
// Handshake: an operand set is accepted on a rising edge where
// load_valid & load_ready. load_ready is high only in IDLE. Nothing the
// producer drives while load_ready is low has any effect.
//
// Optional feature: define SC_SNG_RESEED_EN to reload both LFSRs with their
// seeds on every accepted handshake. Identical loads then give identical
// streams. Without it, each run continues from where the previous run left
// the LFSRs.
//
// Ports:
//   clk          in   1    rising-edge clock
//   reset        in   1    asynchronous active-low reset
//   load_valid   in   1    operand set offered
//   load_ready   out  1    operands can be accepted (IDLE)
//   load_x       in   N*W  activations, lane i = [i*W +: W]
//   load_w       in   N*W  weights, lane i = [i*W +: W]
//   din          out  N    activation bitstreams
//   weight       out  N    weight bitstreams
//   sel          out  K    mux select for the current stream cycle
//   stream_valid out  1    din/weight/sel carry a live stream bit
//   done         out  1    one-cycle pulse after the last stream bit
//   state_dbg    out  2    current FSM state
// -----------------------------------------------------------------------------
module sc_sng_bank
    import sc_pkg::*;
#(
    parameter int           K          = 3,
    parameter int           W          = 8,
    parameter int           STREAM_LEN = (1 << W) - 1,
    parameter logic [W-1:0] SEED_X     = W'(8'h01),
    parameter logic [W-1:0] SEED_W     = W'(8'hA5)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [(2**K)*W-1:0]   load_x,
    input  logic [(2**K)*W-1:0]   load_w,
    output logic [(2**K)-1:0]     din,
    output logic [(2**K)-1:0]     weight,
    output logic [K-1:0]          sel,
    output logic                  stream_valid,
    output logic                  done,
    output sng_state_t            state_dbg
);

    localparam int              N    = 1 << K;
    localparam int              CW   = $clog2(STREAM_LEN + 1);
    localparam logic [CW-1:0]   LAST = CW'(STREAM_LEN - 1);

    sng_state_t     state_q, state_d;
    logic [N*W-1:0] x_q, x_d, w_q, w_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [K-1:0]   sel_q, sel_d;
    logic [W-1:0]   lfsr_x, lfsr_w;
    logic [N-1:0]   din_bits, weight_bits;
    logic           handshake, run_en, reseed;

    assign handshake = load_valid & load_ready;
    assign run_en    = (state_q == RUN);

`ifdef SC_SNG_RESEED_EN
    assign reseed = handshake;
`else
    assign reseed = 1'b0;
`endif

    sc_lfsr #(.W(W), .SEED(SEED_X)) u_lfsr_x (
        .clk    (clk),
        .reset  (reset),
        .en     (run_en),
        .reseed (reseed),
        .state  (lfsr_x)
    );

    sc_lfsr #(.W(W), .SEED(SEED_W)) u_lfsr_w (
        .clk    (clk),
        .reset  (reset),
        .en     (run_en),
        .reseed (reseed),
        .state  (lfsr_w)
    );

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. cnt_q counts stream bits already shown, so the run ends
    // on the cycle that shows bit STREAM_LEN-1.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (handshake) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs. The stream outputs depend only on flopped state, LFSRs
    // and operands, so they are forced to zero as soon as reset drops.
    always_comb begin
        load_ready   = 1'b0;
        stream_valid = 1'b0;
        done         = 1'b0;
        din          = '0;
        weight       = '0;
        sel          = '0;
        case (state_q)
            IDLE: load_ready = 1'b1;
            RUN: begin
                stream_valid = 1'b1;
                din          = din_bits;
                weight       = weight_bits;
                sel          = sel_q;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign state_dbg = state_q;

    // Operand capture plus the cycle and select counters
    always_comb begin
        x_d   = x_q;
        w_d   = w_q;
        cnt_d = cnt_q;
        sel_d = sel_q;
        if (handshake) begin
            x_d   = load_x;
            w_d   = load_w;
            cnt_d = '0;
            sel_d = '0;
        end else if (run_en) begin
            cnt_d = cnt_q + 1'b1;
            sel_d = sel_q + 1'b1;   // N = 2**K, so the natural wrap is N-1 -> 0
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q   <= '0;
            w_q   <= '0;
            cnt_q <= '0;
            sel_q <= '0;
        end else begin
            x_q   <= x_d;
            w_q   <= w_d;
            cnt_q <= cnt_d;
            sel_q <= sel_d;
        end
    end

    // Per-lane comparators. The LFSR covers 1..2**W-1 once per period, so a
    // lane holding value v emits exactly v ones over a full period.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            din_bits[i]    = (lfsr_x <= x_q[i*W +: W]);
            weight_bits[i] = (lfsr_w <= w_q[i*W +: W]);
        end
    end

endmodule
